// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with configurable weights, threshold and refractory period.
// Define LIF_NEURON_LEAK_EN to enable membrane leak; otherwise it is pure integrate-and-fire.
module lif_neuron #(
  parameter int N_IN    = 4,
  parameter int W       = 8,
  parameter int LEAK_SH = 3,
  parameter int REF_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N_IN-1:0]            spike_in,
  input  logic                       cfg_we,
  input  logic [$clog2(N_IN+1)-1:0]  cfg_addr,
  input  logic [W-1:0]               cfg_data,
  output logic                       spike_out,
  output logic [W-1:0]               membrane,
  output logic                       refractory
);

  localparam int AW = $clog2(N_IN+1);
  localparam int SW = W + $clog2(N_IN) + 1;

  typedef enum logic {INTEG, REFRAC} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [W-1:0]  weight_q [N_IN];
  logic [W-1:0]  thr_q;

  logic [W-1:0]  leak;
  logic [SW-1:0] syn_sum;
  logic [SW-1:0] sum;
  logic [SW-1:0] over;
  logic          fire;
  logic [W-1:0]  mem_next;

  if (LEAK_SH < 1 || LEAK_SH >= W) begin : g_bad_leak_sh
    $error("lif_neuron: LEAK_SH out of range");
  end

`ifdef LIF_NEURON_LEAK_EN
  logic [W-1:0] shifted;
  assign shifted = membrane >> LEAK_SH;
  // Force a decay of 1 once the shift rounds to zero so the membrane reaches 0.
  assign leak = (shifted == '0 && membrane != '0) ? W'(1) : shifted;
`else
  assign leak = '0;
`endif

  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) syn_sum = syn_sum + SW'(weight_q[i]);
    end
  end

  assign sum      = SW'(membrane) - SW'(leak) + syn_sum;
  assign fire     = (sum >= SW'(thr_q));
  assign over     = fire ? (sum - SW'(thr_q)) : sum;
  assign mem_next = (|over[SW-1:W]) ? '1 : over[W-1:0];

  assign refractory = (state == REFRAC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INTEG;
      cnt       <= '0;
      membrane  <= '0;
      spike_out <= 1'b0;
    end else begin
      spike_out <= 1'b0;
      if (en) begin
        unique case (1'b1)
          (state == INTEG): begin
            membrane  <= mem_next;
            spike_out <= fire;
            if (fire && REF_CYC > 0) begin
              state <= REFRAC;
              cnt   <= 8'(REF_CYC);
            end
          end
          (state == REFRAC): begin
            if (cnt <= 8'd1) begin
              state <= INTEG;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= '0;
      thr_q <= {1'b1, {(W-1){1'b0}}};
    end else if (cfg_we) begin
      if (cfg_addr == AW'(N_IN)) thr_q <= cfg_data;
      for (int i = 0; i < N_IN; i++) begin
        if (cfg_addr == AW'(i)) weight_q[i] <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed testbench for lif_neuron with an arithmetic reference model.
// Expectations follow LIF_NEURON_LEAK_EN when it is defined for the build.
module tb_lif_neuron;

  localparam int N_IN    = 4;
  localparam int W       = 8;
  localparam int LEAK_SH = 3;
  localparam int REF_CYC = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [N_IN-1:0] spike_in = '0;
  logic            cfg_we = 1'b0;
  logic [2:0]      cfg_addr = '0;
  logic [W-1:0]    cfg_data = '0;
  logic            spike_out;
  logic [W-1:0]    membrane;
  logic            refractory;

  int checks = 0;
  int errors = 0;

  int m_mem = 0;
  int m_thr = 128;
  int m_ref = 0;
  int m_spk = 0;
  int m_w [N_IN];

`ifdef LIF_NEURON_LEAK_EN
  int e_mem [6] = '{64, 120, 41, 41, 41, 100};
  int e_spk [6] = '{0, 0, 1, 0, 0, 0};
  int e_ref [6] = '{0, 0, 1, 1, 0, 0};
  int e_thr_a = 57;
  int e_thr_b = 30;
`else
  int e_mem [6] = '{64, 0, 0, 0, 64, 0};
  int e_spk [6] = '{0, 1, 0, 0, 0, 1};
  int e_ref [6] = '{0, 1, 1, 0, 0, 1};
  int e_thr_a = 60;
  int e_thr_b = 40;
`endif

  lif_neuron #(
    .N_IN(N_IN), .W(W), .LEAK_SH(LEAK_SH), .REF_CYC(REF_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spike_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .spike_out(spike_out), .membrane(membrane), .refractory(refractory)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int leak_of(input int m);
    int lk;
`ifdef LIF_NEURON_LEAK_EN
    lk = m >> LEAK_SH;
    if (lk == 0 && m > 0) lk = 1;
`else
    lk = 0;
`endif
    return lk;
  endfunction

  // Reference model: m_ref counts refractory cycles still to serve.
  always @(posedge clk or negedge rst_n) begin
    int s;
    if (!rst_n) begin
      m_mem = 0;
      m_spk = 0;
      m_ref = 0;
      m_thr = 1 << (W - 1);
      foreach (m_w[i]) m_w[i] = 0;
    end else begin
      m_spk = 0;
      if (en) begin
        if (m_ref > 0) begin
          m_ref = m_ref - 1;
        end else begin
          s = m_mem - leak_of(m_mem);
          for (int i = 0; i < N_IN; i++) if (spike_in[i]) s = s + m_w[i];
          if (s >= m_thr) begin
            s = s - m_thr;
            m_spk = 1;
            m_ref = REF_CYC;
          end
          m_mem = (s > 255) ? 255 : s;
        end
      end
      if (cfg_we) begin
        if (int'(cfg_addr) == N_IN) m_thr = int'(cfg_data);
        else if (int'(cfg_addr) < N_IN) m_w[cfg_addr] = int'(cfg_data);
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_spike", int'(spike_out), m_spk);
    chk("cmp_membrane", int'(membrane), m_mem);
    chk("cmp_refractory", int'(refractory), (m_ref > 0) ? 1 : 0);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 8'(d);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_spike", int'(spike_out), 0);
    chk("async_rst_mem", int'(membrane), 0);
    chk("async_rst_refr", int'(refractory), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int nspk;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("reset_spike", int'(spike_out), 0);
    chk("reset_mem", int'(membrane), 0);
    chk("reset_refr", int'(refractory), 0);

    // Integrate and fire against default threshold 128
    cfg_write(0, 64);
    spike_in = 4'b0001;
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("if_mem%0d", k), int'(membrane), e_mem[k]);
      chk($sformatf("if_spk%0d", k), int'(spike_out), e_spk[k]);
      chk($sformatf("if_ref%0d", k), int'(refractory), e_ref[k]);
    end

    // Leak from 100
    en = 1'b0;
    spike_in = '0;
    pulse_reset();
    cfg_write(0, 100);
    spike_in = 4'b0001;
    en = 1'b1;
    cyc();
    chk("leak_start", int'(membrane), 100);
    spike_in = '0;
`ifdef LIF_NEURON_LEAK_EN
    cyc();
    chk("leak_88", int'(membrane), 88);
    cyc();
    chk("leak_77", int'(membrane), 77);
    cyc();
    chk("leak_68", int'(membrane), 68);
    for (int k = 0; k < 60 && membrane != 0; k++) begin
      prev = int'(membrane);
      cyc();
      chk("leak_mono", (int'(membrane) < prev) ? 1 : 0, 1);
    end
    chk("leak_zero", int'(membrane), 0);
`else
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("noleak_hold", int'(membrane), 100);
    end
`endif

    // Saturation
    en = 1'b0;
    pulse_reset();
    for (int i = 0; i < N_IN; i++) cfg_write(i, 100);
    spike_in = 4'hF;
    en = 1'b1;
    cyc();
    chk("sat_mem", int'(membrane), 255);
    chk("sat_spk", int'(spike_out), 1);
    chk("sat_ref", int'(refractory), 1);

    // Reset in first refractory cycle
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("post_rst_spk", int'(spike_out), 0);
    end

    // Config edge cases
    en = 1'b0;
    spike_in = '0;
    cfg_write(0, 30);
    cfg_write(5, 255);
    spike_in = 4'hF;
    en = 1'b1;
    cyc();
    chk("addr5_mem", int'(membrane), 30);
    chk("addr5_spk", int'(spike_out), 0);
    cfg_write(4, 50);
    chk("thr_old_mem", int'(membrane), e_thr_a);
    chk("thr_old_spk", int'(spike_out), 0);
    cyc();
    chk("thr_new_spk", int'(spike_out), 1);
    chk("thr_new_mem", int'(membrane), e_thr_b);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("freeze_mem", int'(membrane), e_thr_b);
      chk("freeze_ref", int'(refractory), 1);
      chk("freeze_spk", int'(spike_out), 0);
    end
    en = 1'b1;
    cyc();
    chk("unfreeze_ref1", int'(refractory), 1);
    cyc();
    chk("unfreeze_ref0", int'(refractory), 0);
    chk("unfreeze_mem", int'(membrane), e_thr_b);

    // Threshold 0: fires on every eligible cycle
    en = 1'b0;
    spike_in = '0;
    cfg_write(4, 0);
    en = 1'b1;
    nspk = 0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      if (spike_out) nspk++;
    end
    chk("thr0_spikes", nspk, 3);

    en = 1'b0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
